// File: rtl/tb_run_ctrl_if.sv
// Control/status bundle between the host, the run sequencer, the stimulus generator and the monitor.
// Signal names keep their i_/o_ direction as seen from the sequencer.
interface tb_run_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 i_start;
  logic                 i_abort;
  logic [CNT_WIDTH-1:0] i_num_vec;
  logic [CNT_WIDTH-1:0] i_max_err;
  logic                 i_mon_event;
  logic                 o_mon_reset;
  logic                 o_stim_en;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_pass;
  logic                 o_aborted;
  logic [CNT_WIDTH-1:0] o_vec_cnt;
  logic [CNT_WIDTH-1:0] o_err_cnt;
  logic [CNT_WIDTH-1:0] o_first_err_vec;
  logic                 o_first_err_valid;

  modport master (
    output i_start, i_abort, i_num_vec, i_max_err, i_mon_event,
    input  o_mon_reset, o_stim_en, o_busy, o_done, o_pass, o_aborted,
    input  o_vec_cnt, o_err_cnt, o_first_err_vec, o_first_err_valid
  );

  modport slave (
    input  i_start, i_abort, i_num_vec, i_max_err, i_mon_event,
    output o_mon_reset, o_stim_en, o_busy, o_done, o_pass, o_aborted,
    output o_vec_cnt, o_err_cnt, o_first_err_vec, o_first_err_valid
  );
endinterface

// File: rtl/tb_run_ctrl.sv
// Run sequencer: monitor reset, warm-up, stimulus window, drain, then a one-cycle done with
// pass/fail, saturating error count and the index of the first failing vector.
module tb_run_ctrl #(
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned RST_CYCLES    = 2,
  parameter int unsigned WARMUP_CYCLES = 8,
  parameter int unsigned DRAIN_CYCLES  = 4
) (
  input logic          clk,
  input logic          reset,
  tb_run_ctrl_if.slave bus_io
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StResetMon = 3'd1;
  localparam logic [2:0] StWarmup   = 3'd2;
  localparam logic [2:0] StRun      = 3'd3;
  localparam logic [2:0] StDrain    = 3'd4;
  localparam logic [2:0] StDone     = 3'd5;

  localparam int unsigned TmrMax0 = (RST_CYCLES > WARMUP_CYCLES) ? RST_CYCLES : WARMUP_CYCLES;
  localparam int unsigned TmrMax  = (TmrMax0 > DRAIN_CYCLES) ? TmrMax0 : DRAIN_CYCLES;
  localparam int unsigned TmrW    = $clog2(TmrMax) + 1;

  logic [2:0]           state_q, state_d;
  logic [TmrW-1:0]      tmr_q, tmr_d;
  logic [CNT_WIDTH-1:0] num_vec_q, num_vec_d;
  logic [CNT_WIDTH-1:0] max_err_q, max_err_d;
  logic [CNT_WIDTH-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0] first_vec_q, first_vec_d;
  logic                 first_valid_q, first_valid_d;
  logic                 pass_q, pass_d;
  logic                 aborted_q, aborted_d;

  logic                 ev_sample;
  logic                 abortable;
  logic [CNT_WIDTH-1:0] err_next;

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    num_vec_d     = num_vec_q;
    max_err_d     = max_err_q;
    vec_cnt_d     = vec_cnt_q;
    err_cnt_d     = err_cnt_q;
    first_vec_d   = first_vec_q;
    first_valid_d = first_valid_q;
    pass_d        = pass_q;
    aborted_d     = aborted_q;

    ev_sample = bus_io.i_mon_event && ((state_q == StRun) || (state_q == StDrain));
    abortable = (state_q == StResetMon) || (state_q == StWarmup) ||
                (state_q == StRun) || (state_q == StDrain);
    err_next  = err_cnt_q;
    if (ev_sample && (err_cnt_q != {CNT_WIDTH{1'b1}})) begin
      err_next = err_cnt_q + CNT_WIDTH'(1);
    end

    if (ev_sample) begin
      err_cnt_d = err_next;
      if (!first_valid_q) begin
        first_vec_d   = vec_cnt_q;
        first_valid_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (bus_io.i_start) begin
          num_vec_d     = bus_io.i_num_vec;
          max_err_d     = bus_io.i_max_err;
          vec_cnt_d     = '0;
          err_cnt_d     = '0;
          first_vec_d   = '0;
          first_valid_d = 1'b0;
          pass_d        = 1'b0;
          aborted_d     = 1'b0;
          tmr_d         = '0;
          state_d       = StResetMon;
        end
      end
      StResetMon: begin
        if (tmr_q == TmrW'(RST_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = StWarmup;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StWarmup: begin
        if (tmr_q == TmrW'(WARMUP_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = (num_vec_q == '0) ? StDrain : StRun;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StRun: begin
        vec_cnt_d = vec_cnt_q + CNT_WIDTH'(1);
        // The vector issued in the cycle the limit is hit still counts; stop from the next one.
        if ((vec_cnt_q == num_vec_q - CNT_WIDTH'(1)) ||
            ((max_err_q != '0) && (err_next >= max_err_q))) begin
          tmr_d   = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (tmr_q == TmrW'(DRAIN_CYCLES - 1)) begin
          pass_d  = (err_next == '0) && !aborted_q;
          state_d = StDone;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abortable && bus_io.i_abort) begin
      state_d   = StDone;
      aborted_d = 1'b1;
      pass_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      tmr_q         <= '0;
      num_vec_q     <= '0;
      max_err_q     <= '0;
      vec_cnt_q     <= '0;
      err_cnt_q     <= '0;
      first_vec_q   <= '0;
      first_valid_q <= 1'b0;
      pass_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      num_vec_q     <= num_vec_d;
      max_err_q     <= max_err_d;
      vec_cnt_q     <= vec_cnt_d;
      err_cnt_q     <= err_cnt_d;
      first_vec_q   <= first_vec_d;
      first_valid_q <= first_valid_d;
      pass_q        <= pass_d;
      aborted_q     <= aborted_d;
    end
  end

  assign bus_io.o_mon_reset       = (state_q == StResetMon);
  assign bus_io.o_stim_en         = (state_q == StRun);
  assign bus_io.o_busy            = (state_q != StIdle);
  assign bus_io.o_done            = (state_q == StDone);
  assign bus_io.o_pass            = pass_q;
  assign bus_io.o_aborted         = aborted_q;
  assign bus_io.o_vec_cnt         = vec_cnt_q;
  assign bus_io.o_err_cnt         = err_cnt_q;
  assign bus_io.o_first_err_vec   = first_vec_q;
  assign bus_io.o_first_err_valid = first_valid_q;

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Self-checking bench for tb_run_ctrl: per-scenario tasks, expected run results queued at start
// and compared when o_done pulses.
module tb_tb_run_ctrl;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tb_run_ctrl_if #(.CNT_WIDTH(W)) bus ();

  tb_run_ctrl #(
    .CNT_WIDTH    (W),
    .RST_CYCLES   (2),
    .WARMUP_CYCLES(8),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  typedef struct {
    logic         pass;
    logic         aborted;
    logic [W-1:0] vec;
    logic [W-1:0] err;
    logic [W-1:0] fvec;
    logic         fvalid;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected end-of-run status, from the run parameters and the vector indices that fail.
  function automatic exp_t model(input int num, input int maxe, input logic [31:0] ev,
                                 input int abort_at);
    exp_t e;
    e.pass = 1'b0; e.aborted = 1'b0; e.vec = '0; e.err = '0; e.fvec = '0; e.fvalid = 1'b0;
    for (int v = 0; v < num; v++) begin
      if (v < 32 && ev[v]) begin
        if (e.err == 0) begin
          e.fvec   = W'(v);
          e.fvalid = 1'b1;
        end
        e.err = e.err + 1;
      end
      e.vec = W'(v + 1);
      if (v == abort_at) begin
        e.aborted = 1'b1;
        break;
      end
      if (maxe != 0 && e.err >= W'(maxe)) break;
    end
    e.pass = (e.err == 0) && !e.aborted;
    return e;
  endfunction

  task automatic clear_inputs();
    bus.i_start     = 1'b0;
    bus.i_abort     = 1'b0;
    bus.i_num_vec   = '0;
    bus.i_max_err   = '0;
    bus.i_mon_event = 1'b0;
  endtask

  // Index 0 is the first cycle after the accepted start (first RESET_MON cycle).
  task automatic run(input int num, input int maxe, input logic [31:0] ev, input int abort_at,
                     input bit warm_ev, input bit mid_start, input bit abort_with_start,
                     output int mr_cnt, output int st_cnt, output int st_first,
                     output int st_last, output int done_idx, output bit st_gap);
    exp_t e;
    mr_cnt = 0; st_cnt = 0; st_first = -1; st_last = -1; done_idx = -1; st_gap = 1'b0;
    bus.i_num_vec = W'(num);
    bus.i_max_err = W'(maxe);
    bus.i_start   = 1'b1;
    bus.i_abort   = abort_with_start;
    sb.push_back(model(num, maxe, ev, abort_at));
    @(negedge clk);
    bus.i_start   = 1'b0;
    bus.i_abort   = 1'b0;
    bus.i_num_vec = W'(99);
    bus.i_max_err = W'(0);
    for (int idx = 0; idx < 300; idx++) begin
      mr_cnt += int'(bus.o_mon_reset);
      if (bus.o_stim_en) begin
        if (st_first < 0) st_first = idx;
        if (st_last >= 0 && st_last != idx - 1) st_gap = 1'b1;
        st_last = idx;
        st_cnt++;
      end
      if (bus.o_done) begin
        done_idx = idx;
        break;
      end
      bus.i_mon_event = (bus.o_stim_en && bus.o_vec_cnt < W'(32) && ev[bus.o_vec_cnt[4:0]])
                        || (warm_ev && idx == 5);
      bus.i_abort     = bus.o_stim_en && abort_at >= 0 && bus.o_vec_cnt == W'(abort_at);
      bus.i_start     = mid_start && idx == 12;
      @(negedge clk);
    end
    bus.i_mon_event = 1'b0;
    bus.i_abort     = 1'b0;
    bus.i_start     = 1'b0;
    n_checks++;
    if (done_idx < 0) begin
      n_fail++;
      $display("FAIL done_timeout: no o_done within 300 cycles (num_vec=%0d)", num);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: o_done with no expected run queued");
    end else begin
      e = sb.pop_front();
      n_checks += 5;
      if (bus.o_pass !== e.pass || bus.o_aborted !== e.aborted) begin
        n_fail++;
        $display("FAIL pass_aborted: got pass=%b aborted=%b expected pass=%b aborted=%b",
                 bus.o_pass, bus.o_aborted, e.pass, e.aborted);
      end
      if (bus.o_vec_cnt !== e.vec) begin
        n_fail++;
        $display("FAIL vec_cnt: got %0d expected %0d", bus.o_vec_cnt, e.vec);
      end
      if (bus.o_err_cnt !== e.err) begin
        n_fail++;
        $display("FAIL err_cnt: got %0d expected %0d", bus.o_err_cnt, e.err);
      end
      if (bus.o_first_err_valid !== e.fvalid ||
          (e.fvalid && bus.o_first_err_vec !== e.fvec)) begin
        n_fail++;
        $display("FAIL first_err: got valid=%b vec=%0d expected valid=%b vec=%0d",
                 bus.o_first_err_valid, bus.o_first_err_vec, e.fvalid, e.fvec);
      end
      if (bus.o_stim_en !== 1'b0 || bus.o_mon_reset !== 1'b0) begin
        n_fail++;
        $display("FAIL done_outputs: got stim_en=%b mon_reset=%b expected 0 0",
                 bus.o_stim_en, bus.o_mon_reset);
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done: got busy=%b done=%b expected 0 0", bus.o_busy, bus.o_done);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 2;
    if ({bus.o_busy, bus.o_mon_reset, bus.o_stim_en, bus.o_done, bus.o_pass, bus.o_aborted,
         bus.o_first_err_valid} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000000", {bus.o_busy, bus.o_mon_reset,
               bus.o_stim_en, bus.o_done, bus.o_pass, bus.o_aborted, bus.o_first_err_valid});
    end
    if (bus.o_vec_cnt !== '0 || bus.o_err_cnt !== '0 || bus.o_first_err_vec !== '0) begin
      n_fail++;
      $display("FAIL reset_counts: got vec=%0d err=%0d first=%0d expected 0 0 0",
               bus.o_vec_cnt, bus.o_err_cnt, bus.o_first_err_vec);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int mr, sc, sf, sl, di;
    bit gap;
    run(10, 0, 32'h0, -1, 1'b0, 1'b0, 1'b0, mr, sc, sf, sl, di, gap);
    n_checks += 4;
    if (mr != 2) begin
      n_fail++; $display("FAIL nom_mon_reset_cycles: got %0d expected 2", mr);
    end
    if (sf != 10) begin
      n_fail++; $display("FAIL nom_stim_start: got cycle %0d expected 10", sf);
    end
    if (sc != 10 || gap) begin
      n_fail++; $display("FAIL nom_stim_len: got %0d (gap=%b) expected 10 (gap=0)", sc, gap);
    end
    if (di != sl + 5) begin
      n_fail++; $display("FAIL nom_done_delay: got %0d expected %0d", di - sl, 5);
    end
  endtask

  task automatic test_errors();
    int mr, sc, sf, sl, di;
    bit gap;
    run(10, 0, (32'h1 << 3) | (32'h1 << 7), -1, 1'b1, 1'b1, 1'b0, mr, sc, sf, sl, di, gap);
    n_checks++;
    if (sc != 10) begin
      n_fail++; $display("FAIL err_stim_len: got %0d expected 10", sc);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.o_err_cnt !== W'(2) || bus.o_first_err_vec !== W'(3) || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_hold_idle: got err=%0d first=%0d busy=%b expected 2 3 0",
               bus.o_err_cnt, bus.o_first_err_vec, bus.o_busy);
    end
  endtask

  task automatic test_limit();
    int mr, sc, sf, sl, di;
    bit gap;
    run(10, 1, 32'h1 << 5, -1, 1'b0, 1'b0, 1'b0, mr, sc, sf, sl, di, gap);
    n_checks += 2;
    if (sc != 6) begin
      n_fail++; $display("FAIL lim_stim_len: got %0d expected 6", sc);
    end
    if (di != sl + 5) begin
      n_fail++; $display("FAIL lim_done_delay: got %0d expected 5", di - sl);
    end
  endtask

  task automatic test_zero_vec();
    int mr, sc, sf, sl, di;
    bit gap;
    run(0, 0, 32'h0, -1, 1'b0, 1'b0, 1'b1, mr, sc, sf, sl, di, gap);
    n_checks += 2;
    if (sc != 0) begin
      n_fail++; $display("FAIL zero_stim: got %0d stim cycles expected 0", sc);
    end
    if (di != 14) begin
      n_fail++; $display("FAIL zero_done_idx: got %0d expected 14", di);
    end
  endtask

  task automatic test_abort();
    int mr, sc, sf, sl, di;
    bit gap;
    run(20, 0, 32'h0, 4, 1'b0, 1'b1, 1'b0, mr, sc, sf, sl, di, gap);
    n_checks += 2;
    if (sc != 5) begin
      n_fail++; $display("FAIL abort_stim_len: got %0d expected 5", sc);
    end
    if (di != sl + 1) begin
      n_fail++; $display("FAIL abort_done_delay: got %0d expected 1", di - sl);
    end
  endtask

  task automatic test_sync_reset();
    int  mr, sc, sf, sl, di;
    bit  gap, hit;
    int  dones;
    bus.i_num_vec = W'(10);
    bus.i_max_err = '0;
    bus.i_start   = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.o_stim_en && bus.o_vec_cnt == W'(3)) begin
        hit = 1'b1;
        break;
      end
      bus.i_mon_event = bus.o_stim_en && bus.o_vec_cnt == W'(1);
      @(negedge clk);
    end
    bus.i_mon_event = 1'b0;
    n_checks++;
    if (!hit) begin
      n_fail++; $display("FAIL srst_reach_run: got no RUN at vec 3 expected within 60 cycles");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks += 2;
    if ({bus.o_busy, bus.o_mon_reset, bus.o_stim_en, bus.o_done, bus.o_pass, bus.o_aborted,
         bus.o_first_err_valid} !== 7'b0) begin
      n_fail++;
      $display("FAIL srst_flags: got %b expected 0000000", {bus.o_busy, bus.o_mon_reset,
               bus.o_stim_en, bus.o_done, bus.o_pass, bus.o_aborted, bus.o_first_err_valid});
    end
    if (bus.o_vec_cnt !== '0 || bus.o_err_cnt !== '0 || bus.o_first_err_vec !== '0) begin
      n_fail++;
      $display("FAIL srst_counts: got vec=%0d err=%0d first=%0d expected 0 0 0",
               bus.o_vec_cnt, bus.o_err_cnt, bus.o_first_err_vec);
    end
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      dones += int'(bus.o_done) + int'(bus.o_busy);
      @(negedge clk);
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL srst_quiet: got %0d done/busy cycles expected 0", dones);
    end
    run(3, 0, 32'h0, -1, 1'b0, 1'b0, 1'b0, mr, sc, sf, sl, di, gap);
    n_checks++;
    if (sc != 3 || sf != 10) begin
      n_fail++; $display("FAIL srst_rerun: got stim=%0d start=%0d expected 3 10", sc, sf);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_errors();
    test_limit();
    test_zero_vec();
    test_abort();
    test_sync_reset();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d queued expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
